sb_rx_deframer: RTL and testbench
=================================

Name: sb_rx_deframer

Overview:
- Sideband receive path of the logical layer. Counterpart of the sideband transmit framer that drives sbtx.
- Deserialises the 1-bit sideband line into UART-style symbols: start 0, 8 data bits LSB first, stop 1, one bit per sb_clk.
- Parses DLE/STX … DLE/ETX transactions, removes DLE stuffing, and streams payload bytes plus frame/error strobes to the lane-initialisation control unit.

Parameters:
- MAX_LEN, 64, maximum de-stuffed payload bytes per frame (STX excluded).
- DLE, 8'hFE, data-link-escape symbol.
- ETX, 8'h40, end-of-transaction symbol.

Ports:
- sb_clk  input  1  sideband bit clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sbrx_i  input  1  raw sideband line; idle high.
- rx_enable  input  1  when 0: symbol FSM held in RX_IDLE, parser held in P_WAIT_DLE, no strobes.
- frame_start  output  1  1-cycle pulse; valid STX received.
- frame_stx  output  8  STX byte; held from frame_start until the next frame_start.
- byte_valid  output  1  1-cycle pulse per de-stuffed payload byte.
- byte_data  output  8  payload byte; valid with byte_valid.
- frame_end  output  1  1-cycle pulse on DLE ETX.
- frame_len  output  7  payload byte count; valid with frame_end, held after.
- err  output  1  1-cycle pulse; frame aborted.
- err_code  output  2  01 stop-bit error, 10 overlength, 11 illegal escape; valid with err, held after.

Behaviour:
- Reset (rst=0, async): all outputs 0, both FSMs to idle states, synchroniser flops set to 1.
- sbrx_i passes through a 2-flop synchroniser. "Sampled bit" below means the synchroniser output.
- Symbol FSM:
  - RX_IDLE: sampled 0 → RX_DATA with bit count 0.
  - RX_DATA: shift in LSB first, one bit per cycle; after 8 bits → RX_STOP.
  - RX_STOP: sampled 1 → byte strobe to parser, then RX_IDLE. Sampled 0 → stop-bit error, then RX_IDLE.
  - No glitch filter and no re-check of the start bit. Back-to-back symbols are legal: a start bit may directly follow a stop bit.
- Parser FSM (advances only on a byte strobe or stop-bit error):
  - P_WAIT_DLE: DLE → P_WAIT_STX. Any other byte is discarded silently.
  - P_WAIT_STX:
    - DLE → stay in P_WAIT_STX (repeated lead-in).
    - ETX → P_WAIT_DLE, no strobes (empty marker).
    - Other → frame_start, frame_stx = byte, length = 0, → P_PAYLOAD.
  - P_PAYLOAD:
    - DLE → P_ESC.
    - Other → byte_valid, length+1.
  - P_ESC:
    - DLE → byte_valid with byte_data = FE, length+1, → P_PAYLOAD.
    - ETX → frame_end, frame_len = length, → P_WAIT_DLE.
    - Other → err code 11, → P_WAIT_DLE.
- Overlength: a payload byte arriving when length == MAX_LEN → err code 10, no byte_valid, → P_WAIT_DLE.
- Stop-bit error:
  - In P_PAYLOAD/P_ESC: err code 01, → P_WAIT_DLE, no frame_end.
  - In P_WAIT_DLE/P_WAIT_STX: err code 01, parser returns to P_WAIT_DLE.
- Latency: byte_valid, frame_start, frame_end and err rise after the 3rd sb_clk rising edge following the edge that samples the stop bit at sbrx_i. This is fixed with no variation.
- Strobes are mutually exclusive, with at most one per received symbol. frame_len counts de-stuffed bytes; a zero-payload frame gives frame_len = 0.
- rx_enable deasserted mid-frame: immediate abort, no err. The next frame requires a fresh DLE.
- rst asserted mid-frame: everything clears; no strobes until a complete new frame arrives.

Test Plan:
- Symbols FE,05,11,22,FE,40 back-to-back → frame_start with stx = 05; byte_valid 11 then 22; frame_end with frame_len = 2. First strobe exactly 3 edges after the stop bit of symbol 05.
- Payload 33,FE,FE,44 inside a frame → byte_valid 33, FE, 44; frame_len = 3 (stuffing removed).
- Stop bit forced 0 on the 2nd payload symbol → err with code 01, no frame_end. A following valid frame is received correctly.
- MAX_LEN+1 payload bytes → MAX_LEN byte_valid pulses, then err with code 10; the trailing DLE ETX produces no frame_end.
- FE,07,FE,12 → err with code 11. Stray bytes 55,AA before FE → ignored, no strobes.
- rst pulsed low during the payload of a frame → outputs 0 immediately; that frame's remaining symbols produce no strobes; the next full frame decodes.

Source files
------------

// File: rtl/sb_rx_deframer.sv
// Sideband receive deframer: 2-flop synchroniser, UART-style symbol
// deserialiser and DLE/STX..DLE/ETX transaction parser with de-stuffing.
module sb_rx_deframer #(
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  DLE     = 8'hFE,
  parameter logic [7:0]  ETX     = 8'h40
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx_i,
  input  logic       rx_enable,
  output logic       frame_start,
  output logic [7:0] frame_stx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_end,
  output logic [6:0] frame_len,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned LEN_W = 7;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_WAIT_DLE, P_WAIT_STX, P_PAYLOAD, P_ESC} p_state_e;

  logic [1:0]       sync_q;
  logic             rx_bit;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       sym_byte_q, sym_byte_d;
  logic             sym_stb_q, sym_stb_d;
  logic             sym_err_q, sym_err_d;

  p_state_e         p_state_q, p_state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             len_full;
  logic             fs_q, fs_d;
  logic [7:0]       stx_q, stx_d;
  logic             bv_q, bv_d;
  logic [7:0]       bd_q, bd_d;
  logic             fe_q, fe_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic             err_q, err_d;
  logic [1:0]       ec_q, ec_d;

  // Two-flop synchroniser on the raw line; resets to idle-high.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], sbrx_i};
  end

  assign rx_bit = sync_q[1];

  // Symbol FSM state and strobe registers.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sym_byte_q <= '0;
      sym_stb_q  <= 1'b0;
      sym_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sym_byte_q <= sym_byte_d;
      sym_stb_q  <= sym_stb_d;
      sym_err_q  <= sym_err_d;
    end
  end

  // Symbol FSM next state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sym_byte_d = sym_byte_q;
    sym_stb_d  = 1'b0;
    sym_err_d  = 1'b0;
    if (!rx_enable) begin
      rx_state_d = RX_IDLE;
      bit_cnt_d  = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_bit) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          if (rx_bit) begin
            sym_stb_d  = 1'b1;
            sym_byte_d = shift_q;
          end else begin
            sym_err_d = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      p_state_q <= P_WAIT_DLE;
      len_q     <= '0;
      fs_q      <= 1'b0;
      stx_q     <= '0;
      bv_q      <= 1'b0;
      bd_q      <= '0;
      fe_q      <= 1'b0;
      flen_q    <= '0;
      err_q     <= 1'b0;
      ec_q      <= '0;
    end else begin
      p_state_q <= p_state_d;
      len_q     <= len_d;
      fs_q      <= fs_d;
      stx_q     <= stx_d;
      bv_q      <= bv_d;
      bd_q      <= bd_d;
      fe_q      <= fe_d;
      flen_q    <= flen_d;
      err_q     <= err_d;
      ec_q      <= ec_d;
    end
  end

  assign len_full = (len_q == LEN_W'(MAX_LEN));

  // Parser next state: frame delimiting, de-stuffing, length and error checks.
  always_comb begin
    p_state_d = p_state_q;
    len_d     = len_q;
    fs_d      = 1'b0;
    bv_d      = 1'b0;
    fe_d      = 1'b0;
    err_d     = 1'b0;
    stx_d     = stx_q;
    bd_d      = bd_q;
    flen_d    = flen_q;
    ec_d      = ec_q;
    if (!rx_enable) begin
      p_state_d = P_WAIT_DLE;
    end else if (sym_err_q) begin
      err_d     = 1'b1;
      ec_d      = 2'b01;
      p_state_d = P_WAIT_DLE;
    end else if (sym_stb_q) begin
      case (p_state_q)
        P_WAIT_DLE: begin
          if (sym_byte_q == DLE) p_state_d = P_WAIT_STX;
        end
        P_WAIT_STX: begin
          if (sym_byte_q == ETX) begin
            p_state_d = P_WAIT_DLE;
          end else if (sym_byte_q != DLE) begin
            fs_d      = 1'b1;
            stx_d     = sym_byte_q;
            len_d     = '0;
            p_state_d = P_PAYLOAD;
          end
        end
        P_PAYLOAD: begin
          if (sym_byte_q == DLE) begin
            p_state_d = P_ESC;
          end else if (len_full) begin
            err_d     = 1'b1;
            ec_d      = 2'b10;
            p_state_d = P_WAIT_DLE;
          end else begin
            bv_d  = 1'b1;
            bd_d  = sym_byte_q;
            len_d = len_q + LEN_W'(1);
          end
        end
        P_ESC: begin
          if (sym_byte_q == DLE) begin
            if (len_full) begin
              err_d     = 1'b1;
              ec_d      = 2'b10;
              p_state_d = P_WAIT_DLE;
            end else begin
              bv_d      = 1'b1;
              bd_d      = DLE;
              len_d     = len_q + LEN_W'(1);
              p_state_d = P_PAYLOAD;
            end
          end else if (sym_byte_q == ETX) begin
            fe_d      = 1'b1;
            flen_d    = len_q;
            p_state_d = P_WAIT_DLE;
          end else begin
            err_d     = 1'b1;
            ec_d      = 2'b11;
            p_state_d = P_WAIT_DLE;
          end
        end
        default: p_state_d = P_WAIT_DLE;
      endcase
    end
  end

  assign frame_start = fs_q;
  assign frame_stx   = stx_q;
  assign byte_valid  = bv_q;
  assign byte_data   = bd_q;
  assign frame_end   = fe_q;
  assign frame_len   = flen_q;
  assign err         = err_q;
  assign err_code    = ec_q;

endmodule

// File: tb/tb_sb_rx_deframer.sv
// Directed bench for sb_rx_deframer: serialises symbols onto sbrx_i and
// compares the captured strobe stream against hand-written expectations.
module tb_sb_rx_deframer;

  logic       sb_clk;
  logic       rst;
  logic       sbrx_i;
  logic       rx_enable;
  logic       frame_start;
  logic [7:0] frame_stx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_end;
  logic [6:0] frame_len;
  logic       err;
  logic [1:0] err_code;

  // Event record: kind 1=start(stx) 2=byte 3=end(len) 4=err(code)
  typedef struct packed {
    logic [3:0] kind;
    logic [7:0] d;
  } ev_t;

  ev_t ev_q[$];
  int  cyc_q[$];
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int multi = 0;
  int last_stop = 0;
  int s05;

  sb_rx_deframer dut (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .sbrx_i      (sbrx_i),
    .rx_enable   (rx_enable),
    .frame_start (frame_start),
    .frame_stx   (frame_stx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_end   (frame_end),
    .frame_len   (frame_len),
    .err         (err),
    .err_code    (err_code)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  // Capture strobes 1 time unit after each rising edge.
  always begin
    @(posedge sb_clk);
    cyc = cyc + 1;
    #1;
    if ((int'(frame_start) + int'(byte_valid) + int'(frame_end) + int'(err)) > 1)
      multi = multi + 1;
    if (frame_start) begin
      ev_q.push_back({4'd1, frame_stx}); cyc_q.push_back(cyc);
    end else if (byte_valid) begin
      ev_q.push_back({4'd2, byte_data}); cyc_q.push_back(cyc);
    end else if (frame_end) begin
      ev_q.push_back({4'd3, 8'(frame_len)}); cyc_q.push_back(cyc);
    end else if (err) begin
      ev_q.push_back({4'd4, 8'(err_code)}); cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send_sym(input logic [7:0] b, input logic stopb);
    @(negedge sb_clk) sbrx_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sb_clk) sbrx_i = b[i];
    end
    @(negedge sb_clk) sbrx_i = stopb;
    last_stop = cyc + 1;
    if (!stopb) begin
      @(negedge sb_clk) sbrx_i = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sb_clk);
  endtask

  task automatic clear_ev();
    ev_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_ev(input logic [3:0] kind, input logic [7:0] d);
    exp_q.push_back({kind, d});
  endtask

  task automatic check_all(input string tag);
    ev_t obs;
    chk($sformatf("%s count", tag), 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < ev_q.size()) ? ev_q[i] : 12'hFFF;
      chk($sformatf("%s ev[%0d]", tag, i), 32'(obs), 32'(exp_q[i]));
    end
  endtask

  function automatic logic [28:0] outs();
    return {frame_start, frame_stx, byte_valid, byte_data, frame_end,
            frame_len, err, err_code};
  endfunction

  initial begin
    rst       = 1'b0;
    sbrx_i    = 1'b1;
    rx_enable = 1'b1;
    #12;
    chk("reset outputs", 32'(outs()), 32'd0);
    @(negedge sb_clk) rst = 1'b1;
    idle(4);

    // Basic frame and first-strobe latency
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h05, 1'b1);
    s05 = last_stop;
    send_sym(8'h11, 1'b1);
    send_sym(8'h22, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h05);
    expect_ev(4'd2, 8'h11);
    expect_ev(4'd2, 8'h22);
    expect_ev(4'd3, 8'd2);
    check_all("basic");
    chk("basic latency", 32'((cyc_q.size() > 0) ? cyc_q[0] : -1), 32'(s05 + 3));
    chk("basic stx held", 32'(frame_stx), 32'h05);
    chk("basic len held", 32'(frame_len), 32'd2);

    // DLE stuffing removed
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h09, 1'b1);
    send_sym(8'h33, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h44, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h09);
    expect_ev(4'd2, 8'h33);
    expect_ev(4'd2, 8'hFE);
    expect_ev(4'd2, 8'h44);
    expect_ev(4'd3, 8'd3);
    check_all("stuff");

    // Stop-bit error on 2nd payload symbol, trailing DLE ETX ignored, then recovery
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h0A, 1'b1);
    send_sym(8'h55, 1'b1);
    send_sym(8'h66, 1'b0);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h0A);
    expect_ev(4'd2, 8'h55);
    expect_ev(4'd4, 8'h01);
    check_all("stoperr");
    chk("stoperr code held", 32'(err_code), 32'd1);
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h0B, 1'b1);
    send_sym(8'h77, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h0B);
    expect_ev(4'd2, 8'h77);
    expect_ev(4'd3, 8'd1);
    check_all("recover");

    // Exactly 64 payload bytes is accepted
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h02, 1'b1);
    expect_ev(4'd1, 8'h02);
    for (int i = 0; i < 64; i++) begin
      send_sym(8'(i), 1'b1);
      expect_ev(4'd2, 8'(i));
    end
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd3, 8'd64);
    check_all("maxlen");

    // 65 payload bytes: overlength, trailing DLE ETX gives no frame_end
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h01, 1'b1);
    expect_ev(4'd1, 8'h01);
    for (int i = 0; i < 65; i++) begin
      send_sym(8'(i), 1'b1);
      if (i < 64) expect_ev(4'd2, 8'(i));
    end
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd4, 8'h02);
    check_all("overlen");

    // Stray bytes ignored, then illegal escape
    clear_ev();
    send_sym(8'h55, 1'b1);
    send_sym(8'hAA, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h07, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h12, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h07);
    expect_ev(4'd4, 8'h03);
    check_all("illesc");

    // rx_enable dropped mid-frame: silent abort
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h0E, 1'b1);
    send_sym(8'h99, 1'b1);
    idle(6);
    @(negedge sb_clk) rx_enable = 1'b0;
    idle(3);
    @(negedge sb_clk) rx_enable = 1'b1;
    send_sym(8'hAA, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h0E);
    expect_ev(4'd2, 8'h99);
    check_all("enable");

    // Asynchronous reset mid-payload
    send_sym(8'hFE, 1'b1);
    send_sym(8'h0C, 1'b1);
    send_sym(8'h33, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst outputs", 32'(outs()), 32'd0);
    clear_ev();
    @(negedge sb_clk) rst = 1'b1;
    send_sym(8'h44, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    check_all("postrst quiet");
    clear_ev();
    send_sym(8'hFE, 1'b1);
    send_sym(8'h0D, 1'b1);
    send_sym(8'h88, 1'b1);
    send_sym(8'hFE, 1'b1);
    send_sym(8'h40, 1'b1);
    idle(6);
    expect_ev(4'd1, 8'h0D);
    expect_ev(4'd2, 8'h88);
    expect_ev(4'd3, 8'd1);
    check_all("postrst frame");

    chk("exclusive strobes", 32'(multi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
